// File: rtl/msrv32_iadder_arbiter.sv
// Shares one immediate adder between the branch-target and LSU address ports.
// Define MSRV32_IADDER_RR_EN for round-robin conflicts, else port 0 has priority.
module msrv32_iadder_arbiter #(
   parameter int XLEN = 32
) (
   input  logic            clk_in,
   input  logic            rst_in,
   input  logic            req0_valid_in,
   output logic            req0_ready_out,
   input  logic            req0_src_in,
   input  logic [XLEN-1:0] req0_pc_in,
   input  logic [XLEN-1:0] req0_rs_1_in,
   input  logic [XLEN-1:0] req0_imm_in,
   input  logic            req1_valid_in,
   output logic            req1_ready_out,
   input  logic            req1_src_in,
   input  logic [XLEN-1:0] req1_pc_in,
   input  logic [XLEN-1:0] req1_rs_1_in,
   input  logic [XLEN-1:0] req1_imm_in,
   output logic [XLEN-1:0] pc_out,
   output logic [XLEN-1:0] rs_1_out,
   output logic [XLEN-1:0] imm_out,
   output logic            iadder_src_out,
   input  logic [XLEN-1:0] iadder_in,
   output logic            rsp_valid_out,
   input  logic            rsp_ready_in,
   output logic            rsp_id_out,
   output logic [XLEN-1:0] rsp_addr_out,
   output logic            rsp_misaligned_out
);

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } state_t;

   state_t          state;
   state_t          state_nxt;
   logic            can_accept;
   logic            grant0;
   logic            grant1;
   logic            pick1;
   logic            clr_bit0;
   logic [XLEN-1:0] cap_addr;

`ifdef MSRV32_IADDER_RR_EN
   // Holds the id of the most recent grant; the other port wins a conflict.
   logic rr_ptr;

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         rr_ptr <= 1'b1;
      end else if (grant0 | grant1) begin
         rr_ptr <= grant1;
      end
   end

   assign pick1 = ~rr_ptr;
`else
   assign pick1 = 1'b0;
`endif

   always_comb begin
      state_nxt      = state;
      can_accept     = 1'b0;
      grant0         = 1'b0;
      grant1         = 1'b0;
      pc_out         = '0;
      rs_1_out       = '0;
      imm_out        = '0;
      iadder_src_out = 1'b0;

      if (!rst_in) begin
         can_accept = (state == EMPTY) | rsp_ready_in;
      end

      grant0 = can_accept & req0_valid_in
             & (~req1_valid_in | ~pick1);
      grant1 = can_accept & req1_valid_in
             & (~req0_valid_in | pick1);

      if (grant0) begin
         pc_out         = req0_pc_in;
         rs_1_out       = req0_rs_1_in;
         imm_out        = req0_imm_in;
         iadder_src_out = req0_src_in;
      end else if (grant1) begin
         pc_out         = req1_pc_in;
         rs_1_out       = req1_rs_1_in;
         imm_out        = req1_imm_in;
         iadder_src_out = req1_src_in;
      end

      if (grant0 | grant1) begin
         state_nxt = FULL;
      end else if (state == FULL && rsp_ready_in) begin
         state_nxt = EMPTY;
      end
   end

   assign req0_ready_out = grant0;
   assign req1_ready_out = grant1;
   assign rsp_valid_out  = (state == FULL);

   // JALR targets drop bit 0 of the sum.
   assign clr_bit0 = grant0 & req0_src_in;
   assign cap_addr = {iadder_in[XLEN-1:1],
                      iadder_in[0] & ~clr_bit0};

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state              <= EMPTY;
         rsp_id_out         <= 1'b0;
         rsp_addr_out       <= '0;
         rsp_misaligned_out <= 1'b0;
      end else begin
         state <= state_nxt;
         if (grant0 | grant1) begin
            rsp_id_out         <= grant1;
            rsp_addr_out       <= cap_addr;
            rsp_misaligned_out <= grant0 & cap_addr[1];
         end
      end
   end

endmodule

// File: doc/msrv32_iadder_arbiter.md
# msrv32_iadder_arbiter

- Shares the single immediate adder (`iadder_out = base + imm`) between two requesters.
  - Port 0: control-flow target (branch/JAL/JALR).
  - Port 1: load/store address generation.
- Arbitrates valid/ready requests and drives the adder operands and `iadder_src` select.
- Registers the sum into a one-deep response buffer tagged with the winning requester.
- Sits between the decode/issue logic and the immediate adder in the RV32I core.

## Interface
Parameters:
- `XLEN`, 32, operand/result width.

Ports:
- `clk_in`  in  1  clock, rising edge.
- `rst_in`  in  1  synchronous, active-high reset.
- `req0_valid_in`  in  1  port 0 request.
- `req0_ready_out`  out  1  port 0 request accepted this cycle.
- `req0_src_in`  in  1  1 = rs1 base, 0 = pc base.
- `req0_pc_in`, `req0_rs_1_in`, `req0_imm_in`  in  XLEN  port 0 operands.
- `req1_valid_in`, `req1_ready_out`, `req1_src_in`, `req1_pc_in`, `req1_rs_1_in`, `req1_imm_in`: same as port 0, for port 1.
- `pc_out`, `rs_1_out`, `imm_out`  out  XLEN  operands to the adder.
- `iadder_src_out`  out  1  select to the adder.
- `iadder_in`  in  XLEN  combinational sum returned from the adder.
- `rsp_valid_out`  out  1  response buffer holds a result.
- `rsp_ready_in`  in  1  consumer takes the response.
- `rsp_id_out`  out  1  requester that owns the response (0/1).
- `rsp_addr_out`  out  XLEN  computed address.
- `rsp_misaligned_out`  out  1  port 0 target not 4-byte aligned.

## Operation
- Buffer FSM:
  - EMPTY: `rsp_valid_out=0`.
  - FULL: `rsp_valid_out=1`.
- Accept condition: `can_accept = EMPTY | (FULL & rsp_ready_in)`.
- Grant is combinational. Only when `can_accept` is high:
  - Exactly one valid request: that port is granted.
  - Both valid: port selection per Configuration.
- At most one of `req0_ready_out`/`req1_ready_out` is high per cycle. `reqN_ready_out = grantN`.
- Adder operand drive:
  - Granted port: its `pc`, `rs_1`, `imm` and `src` go to `pc_out`/`rs_1_out`/`imm_out`/`iadder_src_out`.
  - No grant: all four outputs are 0.
- On a grant, the next edge captures the result:
  - `rsp_addr_out <= iadder_in`, `rsp_id_out <= grant id`, FSM -> FULL.
  - Port 0 with src=1 (JALR): bit 0 of the captured address is forced to 0.
  - `rsp_misaligned_out <= (id==0) & captured_addr[1]`.
  - Port 1: `rsp_misaligned_out <= 0`; the LSU checks alignment by access size.
- Transitions:
  - FULL with `rsp_ready_in=1` and no grant -> EMPTY.
  - FULL with `rsp_ready_in=1` and a grant -> stays FULL with new contents (back-to-back throughput 1/cycle).
  - FULL with `rsp_ready_in=0`: holds; all `rsp_*` outputs stable; both ready outputs 0.
- Adder arithmetic is modulo 2^XLEN. Wrap-around is not flagged.
- `rsp_ready_in` while EMPTY is ignored.

## Timing
- Latency: request accepted in cycle N -> `rsp_valid_out=1` with the result in cycle N+1.
- Ready depends combinationally on `reqN_valid_in`, `rsp_ready_in` and FSM state. There is no combinational path from `iadder_in` to any ready.
- Requesters must hold operands stable while `valid=1` and `ready=0`.
- Reset (sync, any cycle, including FULL with a pending request):
  - Next edge: FSM EMPTY.
  - `rsp_valid_out=0`, `rsp_id_out=0`, `rsp_addr_out=0`, `rsp_misaligned_out=0`.
  - Round-robin pointer = 1, so port 0 wins the first conflict.
  - During `rst_in=1` both ready outputs are 0 and operand outputs are 0.
  - A pending buffered response is discarded.

## Configuration
- `MSRV32_IADDER_RR_EN` defined:
  - Round-robin on conflict: the port not granted in the most recent conflict-or-single grant wins.
  - Pointer updates on every grant.
- Not defined:
  - Fixed priority; port 0 always wins a conflict.
  - Port 1 is granted only when port 0 is not valid.
  - The pointer register is not instantiated.
- Single-requester behaviour is identical in both builds.

## Test plan
- Reset, then port 0 `src=0`, `pc=0x08`, `imm=0x04` -> next cycle `rsp_valid_out=1`, `rsp_id_out=0`, `rsp_addr_out=0x0C`, `rsp_misaligned_out=0`.
- Port 1 `src=1`, `rs_1=0x06`, `imm=0x04`, `rsp_ready_in=1` -> `rsp_addr_out=0x0A`, `rsp_id_out=1`, `rsp_misaligned_out=0`.
- Port 0 JALR `src=1`, `rs_1=0x00000011`, `imm=0x00000004` -> `rsp_addr_out=0x14` (bit 0 cleared). Then `rs_1=0x12`, `imm=0` -> `rsp_addr_out=0x12`, `rsp_misaligned_out=1`.
- Both ports valid every cycle with `rsp_ready_in=1`:
  - RR build: ids alternate 0,1,0,1 with one response per cycle.
  - Fixed build: ids 0,0,0,0 and `req1_ready_out` stays 0.
- `rsp_ready_in=0` for 3 cycles while FULL -> both ready outputs 0, `rsp_*` outputs unchanged. Raise `rsp_ready_in` -> the next pending request is accepted that cycle with no bubble.
- Assert `rst_in` while FULL with both requests valid -> next cycle all `rsp_*` outputs 0 and ready outputs 0. After release, port 0 wins the first conflict. `pc=0xFFFFFFFC` + `imm=0x8` -> `rsp_addr_out=0x00000004`.
